// File: rtl/io_hub_pkg.sv
// Shared definitions for the io_hub load path: FSM encodings, status bit
// positions in the decoder status word, error codes and an address helper.
`timescale 1ns/1ps
package io_hub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } load_state_e;

    localparam int STS_START  = 0;
    localparam int STS_FINISH = 1;
    localparam int STS_DREADY = 2;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // Next word-aligned byte address; wraps modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/io_load_fifo.sv
// Small synchronous word FIFO buffering decoded data ahead of memory writes.
// Simultaneous push and pop are legal; a push while full is accepted only
// when a pop frees a slot in the same cycle.
`timescale 1ns/1ps
module io_load_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy; clr flushes without touching data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_load_ctrl.sv
// Program-image load sequencer: holds the core in reset, buffers decoded
// words and writes them to consecutive memory words with a req/ack
// handshake, then releases the core once FINISH is seen and all is drained.
`timescale 1ns/1ps
module io_load_ctrl
    import io_hub_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] status_reg,
    input  logic [31:0] addr_first,
    input  logic [31:0] addr_end,
    input  logic [31:0] data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        core_rst_hold,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [7:0] TO_MAX = 8'(ACK_TIMEOUT);

    load_state_e state_r, state_s;
    logic [2:0]  sts_prev_r;
    logic [2:0]  edge_r;
    logic [31:0] wr_ptr_r, wr_ptr_s;
    logic [31:0] end_addr_r, end_addr_s;
    logic        fin_pend_r, fin_pend_s;
    logic [7:0]  to_cnt_r, to_cnt_s;
    logic        mem_req_r, mem_req_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic        hold_r, hold_s;
    logic        busy_r, busy_s;
    logic        err_r, err_s;
    logic [1:0]  err_code_r, err_code_s;

    logic        start_edge_s, finish_edge_s, dready_edge_s;
    logic        push_s, pop_s, clr_s;
    logic [31:0] fifo_head_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused_s;
    logic        unused_status_s;

    assign unused_status_s = ^status_reg[31:3];
    assign start_edge_s    = edge_r[STS_START];
    assign finish_edge_s   = edge_r[STS_FINISH];
    assign dready_edge_s   = edge_r[STS_DREADY];

    assign mem_req       = mem_req_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign core_rst_hold = hold_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign err_code      = err_code_r;

    io_load_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .push  (push_s),
        .wdata (data),
        .pop   (pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_unused_s)
    );

    // Register the level status bits and flag 0->1 transitions one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_prev_r <= 3'b000;
            edge_r     <= 3'b000;
        end else begin
            sts_prev_r <= status_reg[2:0];
            edge_r     <= status_reg[2:0] & ~sts_prev_r;
        end
    end

    // Next-state, address pointer, timeout and output decisions.
    always_comb begin
        state_s     = state_r;
        wr_ptr_s    = wr_ptr_r;
        end_addr_s  = end_addr_r;
        fin_pend_s  = fin_pend_r;
        to_cnt_s    = to_cnt_r;
        mem_req_s   = mem_req_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        err_s       = err_r;
        err_code_s  = err_code_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clr_s       = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // Only START acts here; stray DREADY/ack are ignored.
                if (start_edge_s) begin
                    clr_s      = 1'b1;
                    fin_pend_s = 1'b0;
                    wr_ptr_s   = addr_first;
                    end_addr_s = addr_end;
                    mem_req_s  = 1'b0;
                    err_s      = 1'b0;
                    err_code_s = ERR_NONE;
                    if (addr_first > addr_end) begin
                        state_s    = ST_ERR;
                        err_s      = 1'b1;
                        err_code_s = ERR_RANGE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            ST_LOAD: begin
                push_s = dready_edge_s;
                if (finish_edge_s) begin
                    fin_pend_s = 1'b1;
                end else begin
                    fin_pend_s = fin_pend_r;
                end
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (wr_ptr_r > end_addr_r) begin
                        // Out-of-range word is dropped, no request issued.
                        state_s    = ST_ERR;
                        err_s      = 1'b1;
                        err_code_s = ERR_RANGE;
                    end else begin
                        mem_req_s   = 1'b1;
                        mem_addr_s  = wr_ptr_r;
                        mem_wdata_s = fifo_head_s;
                        to_cnt_s    = 8'd0;
                        state_s     = ST_WAIT;
                    end
                end else if (fin_pend_r && !dready_edge_s) begin
                    // A word arriving this cycle must still be written first.
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_WAIT: begin
                push_s = dready_edge_s;
                if (finish_edge_s) begin
                    fin_pend_s = 1'b1;
                end else begin
                    fin_pend_s = fin_pend_r;
                end
                if (dready_edge_s && fifo_full_s) begin
                    // No pop can happen while waiting, so a full push overflows.
                    push_s     = 1'b0;
                    mem_req_s  = 1'b0;
                    state_s    = ST_ERR;
                    err_s      = 1'b1;
                    err_code_s = ERR_OVERFLOW;
                end else if (mem_ack) begin
                    mem_req_s = 1'b0;
                    wr_ptr_s  = next_word_addr(wr_ptr_r);
                    state_s   = ST_LOAD;
                end else if (to_cnt_r == TO_MAX) begin
                    mem_req_s  = 1'b0;
                    state_s    = ST_ERR;
                    err_s      = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                end else begin
                    to_cnt_s = to_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase

        hold_s = (state_s != ST_DONE);
        busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= 32'd0;
            end_addr_r  <= 32'd0;
            fin_pend_r  <= 1'b0;
            to_cnt_r    <= 8'd0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            hold_r      <= 1'b1;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
        end else begin
            state_r     <= state_s;
            wr_ptr_r    <= wr_ptr_s;
            end_addr_r  <= end_addr_s;
            fin_pend_r  <= fin_pend_s;
            to_cnt_r    <= to_cnt_s;
            mem_req_r   <= mem_req_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            hold_r      <= hold_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
            err_code_r  <= err_code_s;
        end
    end

endmodule

// File: tb/tb_io_load_ctrl.sv
// Directed bench for io_load_ctrl with a write scoreboard: each word the bench
// expects to reach memory is queued with its address when driven, and popped
// and compared when the DUT raises a new mem_req.
`timescale 1ns/1ps
module tb_io_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] status_reg;
    logic [31:0] addr_first;
    logic [31:0] addr_end;
    logic [31:0] data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        core_rst_hold;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;

    int          checks      = 0;
    int          failures    = 0;
    int          writes_seen = 0;
    int          wbase;
    bit          ack_en      = 1'b0;
    logic        req_prev;
    logic [31:0] exp_ptr;
    logic [63:0] sb [$];
    logic [63:0] exp_wr;

    io_load_ctrl #(
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (255)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .status_reg    (status_reg),
        .addr_first    (addr_first),
        .addr_end      (addr_end),
        .data          (data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .core_rst_hold (core_rst_hold),
        .busy          (busy),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-side model: compare each new request, ack one cycle later if enabled.
    initial begin
        mem_ack  = 1'b0;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mem_ack  = 1'b0;
                req_prev = 1'b0;
            end else begin
                if (mem_req === 1'b1 && req_prev !== 1'b1) begin
                    writes_seen++;
                    checks++;
                    assert (sb.size() != 0) else begin
                        failures++;
                        $error("FAIL unexpected_write observed=0x%0h:0x%0h expected=none", mem_addr, mem_wdata);
                    end
                    if (sb.size() != 0) begin
                        exp_wr = sb.pop_front();
                        check("wr_addr", mem_addr, exp_wr[63:32]);
                        check("wr_data", mem_wdata, exp_wr[31:0]);
                    end
                end
                mem_ack  = (ack_en && mem_req === 1'b1 && mem_ack === 1'b0) ? 1'b1 : 1'b0;
                req_prev = mem_req;
            end
        end
    end

    task automatic pulse(input int bitn);
        status_reg[bitn] = 1'b1;
        repeat (2) @(negedge clk);
        status_reg[bitn] = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_load(input logic [31:0] first, input logic [31:0] last);
        addr_first = first;
        addr_end   = last;
        exp_ptr    = first;
        pulse(0);
    endtask

    task automatic drive_word(input logic [31:0] w, input bit expect_write);
        if (expect_write) begin
            sb.push_back({exp_ptr, w});
            exp_ptr = exp_ptr + 32'd4;
        end
        data = w;
        pulse(2);
    endtask

    task automatic wait_done(input int max, input string tag);
        for (int i = 0; i < max && core_rst_hold !== 1'b0; i++) @(negedge clk);
        check(tag, core_rst_hold, 32'd0);
    endtask

    task automatic wait_err(input int max, input string tag);
        for (int i = 0; i < max && err !== 1'b1; i++) @(negedge clk);
        check(tag, err, 32'd1);
    endtask

    initial begin
        status_reg = 32'd0;
        addr_first = 32'd0;
        addr_end   = 32'd0;
        data       = 32'd0;
        exp_ptr    = 32'd0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", mem_req, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_hold", core_rst_hold, 32'd1);
        check("rst_busy", busy, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_code", err_code, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        drive_word(32'hDEAD_0000, 1'b0);
        check("idle_dready_err", err, 32'd0);
        check("idle_busy", busy, 32'd0);

        // 1: normal load of four words
        ack_en = 1'b1;
        start_load(32'h100, 32'h10C);
        check("t1_busy", busy, 32'd1);
        check("t1_hold", core_rst_hold, 32'd1);
        drive_word(32'hAAAA_0001, 1'b1);
        drive_word(32'hBBBB_0002, 1'b1);
        drive_word(32'hCCCC_0003, 1'b1);
        drive_word(32'hDDDD_0004, 1'b1);
        pulse(1);
        wait_done(50, "t1_done");
        check("t1_err", err, 32'd0);
        check("t1_busy_end", busy, 32'd0);
        check("t1_writes", writes_seen, 32'd4);
        check("t1_sb", sb.size(), 32'd0);

        // 2: third word lands past addr_end
        start_load(32'h200, 32'h204);
        check("t2_hold", core_rst_hold, 32'd1);
        drive_word(32'h2222_0001, 1'b1);
        drive_word(32'h2222_0002, 1'b1);
        drive_word(32'h2222_0003, 1'b0);
        repeat (5) @(negedge clk);
        check("t2_err", err, 32'd1);
        check("t2_code", err_code, 32'd1);
        check("t2_hold_err", core_rst_hold, 32'd1);
        check("t2_req", mem_req, 32'd0);
        check("t2_writes", writes_seen, 32'd6);

        // 3: overflow with ack withheld
        ack_en = 1'b0;
        start_load(32'h300, 32'h3FC);
        check("t3_err_clr", err, 32'd0);
        check("t3_code_clr", err_code, 32'd0);
        drive_word(32'h3333_0001, 1'b1);
        for (int i = 2; i <= 5; i++) drive_word(32'h3333_0000 + 32'(i), 1'b0);
        check("t3_no_err_5", err, 32'd0);
        drive_word(32'h3333_0006, 1'b0);
        repeat (2) @(negedge clk);
        check("t3_err", err, 32'd1);
        check("t3_code", err_code, 32'd2);
        check("t3_req", mem_req, 32'd0);
        check("t3_sb", sb.size(), 32'd0);

        // 4: ack never arrives
        start_load(32'h400, 32'h40C);
        drive_word(32'h4444_0001, 1'b1);
        repeat (150) @(negedge clk);
        check("t4_req_held", mem_req, 32'd1);
        check("t4_no_err_yet", err, 32'd0);
        wait_err(300, "t4_err");
        check("t4_code", err_code, 32'd3);
        check("t4_req", mem_req, 32'd0);
        check("t4_hold", core_rst_hold, 32'd1);

        // 5: FINISH with two buffered words and a same-cycle word
        wbase = writes_seen;
        start_load(32'h500, 32'h5FC);
        drive_word(32'h5555_0001, 1'b1);
        drive_word(32'h5555_0002, 1'b1);
        drive_word(32'h5555_0003, 1'b1);
        check("t5_req", mem_req, 32'd1);
        check("t5_busy", busy, 32'd1);
        sb.push_back({exp_ptr, 32'h5555_0004});
        exp_ptr = exp_ptr + 32'd4;
        data = 32'h5555_0004;
        status_reg[2] = 1'b1;
        status_reg[1] = 1'b1;
        repeat (2) @(negedge clk);
        status_reg[2] = 1'b0;
        status_reg[1] = 1'b0;
        @(negedge clk);
        check("t5_hold_pend", core_rst_hold, 32'd1);
        ack_en = 1'b1;
        wait_done(100, "t5_done");
        check("t5_err", err, 32'd0);
        check("t5_writes", writes_seen - wbase, 32'd4);
        check("t5_sb", sb.size(), 32'd0);

        // 6: reset during WAIT, then a fresh load
        ack_en = 1'b0;
        start_load(32'h600, 32'h6FC);
        drive_word(32'h6666_0001, 1'b1);
        check("t6_req_before", mem_req, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", mem_req, 32'd0);
        check("t6_rst_hold", core_rst_hold, 32'd1);
        check("t6_rst_busy", busy, 32'd0);
        check("t6_rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wbase  = writes_seen;
        ack_en = 1'b1;
        start_load(32'h700, 32'h704);
        sb.push_back({exp_ptr, 32'h7777_0001});
        exp_ptr = exp_ptr + 32'd4;
        data = 32'h7777_0001;
        status_reg[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_lat_2", mem_req, 32'd0);
        @(negedge clk);
        check("t6_lat_3", mem_req, 32'd1);
        status_reg[2] = 1'b0;
        @(negedge clk);
        drive_word(32'h7777_0002, 1'b1);
        pulse(1);
        wait_done(50, "t6_done");
        check("t6_err", err, 32'd0);
        check("t6_writes", writes_seen - wbase, 32'd2);
        check("t6_sb", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
